// File: rtl/r4_mm_digit_feeder.sv
// Operand stage for the radix-4 Montgomery multiplier: fetches A/B/M for one row and streams B as digits.
// Optional feature macro R4_FEEDER_BOOTH_EN selects Booth radix-4 signed digits instead of plain unsigned ones.
module r4_mm_digit_feeder #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 16,
`ifdef R4_FEEDER_BOOTH_EN
    localparam int DW   = 3,
`else
    localparam int DW   = 2,
`endif
    localparam int AW   = $clog2(ROWS) + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      row_sel,
    output logic             mem_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_m,
    output logic [DW-1:0]    digit,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             digit_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef R4_FEEDER_BOOTH_EN
    // B carries one guard zero below bit 0 and two zero bits above so unsigned B recodes exactly.
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int SW   = WIDTH + 3;
`else
    localparam int NDIG = WIDTH / 2;
    localparam int SW   = WIDTH;
`endif
    localparam int CW   = $clog2(NDIG + 1);
    localparam int RW   = AW - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        f_q, f_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  op_a_d, op_m_d;
    logic              mem_en_d;
    logic [AW-1:0]     mem_addr_d;
    logic              digit_valid_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic              row_ok;
    logic              hs;
    logic              at_last;

    assign row_ok  = (row_sel < 32'(ROWS));
    assign hs      = digit_valid & digit_ready;
    assign at_last = (cnt_q == CW'(NDIG - 1));

    assign digit_last = digit_valid & at_last;

`ifdef R4_FEEDER_BOOTH_EN
    function automatic logic [2:0] booth_enc(input logic [2:0] trip);
        logic [2:0] d;
        case (trip)
            3'b001, 3'b010: d = 3'b001;
            3'b011:         d = 3'b010;
            3'b100:         d = 3'b110;
            3'b101, 3'b110: d = 3'b111;
            default:        d = 3'b000;
        endcase
        return d;
    endfunction

    assign digit = digit_valid ? booth_enc(b_sh_q[2:0]) : '0;
`else
    assign digit = digit_valid ? b_sh_q[1:0] : '0;
`endif

    // Next-state and next-value logic; every output except digit/digit_last is registered below.
    always_comb begin
        state_d    = state_q;
        f_d        = f_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        b_sh_d     = b_sh_q;
        op_a_d     = op_a;
        op_m_d     = op_m;
        mem_en_d   = 1'b0;
        mem_addr_d = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (row_ok) begin
                        row_d      = row_sel[RW-1:0];
                        f_d        = 2'd0;
                        mem_en_d   = 1'b1;
                        mem_addr_d = {row_sel[RW-1:0], 2'd0};
                        state_d    = S_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                f_d = f_q + 2'd1;
                if (f_q < 2'd2) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = {row_q, f_q + 2'd1};
                end
                // Read data trails its request by one cycle, hence A/B/M land at f=1/2/3.
                case (f_q)
                    2'd1: op_a_d = mem_rdata;
                    2'd2: begin
`ifdef R4_FEEDER_BOOTH_EN
                        b_sh_d = {2'b00, mem_rdata, 1'b0};
`else
                        b_sh_d = mem_rdata;
`endif
                        cnt_d  = '0;
                    end
                    2'd3: begin
                        op_m_d  = mem_rdata;
                        state_d = S_STREAM;
                    end
                    default: ;
                endcase
            end

            S_STREAM: begin
                if (hs) begin
                    b_sh_d = b_sh_q >> 2;
                    cnt_d  = cnt_q + 1'b1;
                    if (at_last) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        digit_valid_d = (state_d == S_STREAM);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            f_q         <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            b_sh_q      <= '0;
            op_a        <= '0;
            op_m        <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            digit_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            b_sh_q      <= b_sh_d;
            op_a        <= op_a_d;
            op_m        <= op_m_d;
            mem_en      <= mem_en_d;
            mem_addr    <= mem_addr_d;
            digit_valid <= digit_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule
